// File: rtl/attopu_pkg.sv
// attopu_pkg: shared encodings for the attopu core front end.
// Sequencer states, next-PC select codes and opcode field values.
package attopu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] NPC_INC = 2'b00;
    localparam logic [1:0] NPC_REL = 2'b01;
    localparam logic [1:0] NPC_REG = 2'b10;
    localparam logic [1:0] NPC_RSV = 2'b11;

    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_BR  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection with 16-bit wraparound.
// The reserved select falls back to sequential flow and raises bad.
module pc_next
    import attopu_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [1:0]  sel,
    input  logic [15:0] offset,
    input  logic [15:0] reg_target,
    output logic [15:0] next_pc,
    output logic        bad
);

    assign next_pc = sel == NPC_REL ? pc + offset :
                     sel == NPC_REG ? reg_target  : pc + 16'd1;
    assign bad     = sel == NPC_RSV;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: attopu instruction sequencer, fetching one word per instruction
// and presenting it to the decoder for a single EXEC cycle.
module fetch_unit
    import attopu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step_mode,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic        instr_valid,
    input  logic [1:0]  nextPCSel,
    input  logic        halt,
    input  logic [15:0] addr,
    input  logic [15:0] reg_target,
    output logic [15:0] pc,
    output logic        halted,
    output logic        bad_npc,
    output logic [31:0] retired
);

    state_t      state, state_nx;
    logic [15:0] next_pc;
    logic        rsv;

    pc_next u_pc_next (
        .pc         (pc),
        .sel        (nextPCSel),
        .offset     (addr),
        .reg_target (reg_target),
        .next_pc    (next_pc),
        .bad        (rsv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            retired     <= '0;
            bad_npc     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT && imem_valid)
                instruction <= imem_data;
            // a halting instruction leaves pc on itself and is not counted
            if (instr_valid && !halt) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
                bad_npc <= bad_npc | rsv;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_IDLE:   state_nx = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                imem_req = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT:   state_nx = imem_valid ? S_EXEC : S_WAIT;
            S_EXEC: begin
                instr_valid = 1'b1;
                state_nx    = halt ? S_HALTED : (run && !step_mode) ? S_FETCH : S_IDLE;
            end
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign imem_addr = imem_req ? pc : '0;
    assign halted    = state == S_HALTED;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized-latency imem and a toy decoder around fetch_unit,
// checked against an instruction-level model of program flow.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step_mode = 1'b0;
    logic        imem_req, instr_valid, halted, bad_npc, halt;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] imem_addr, instruction, addr, reg_target, pc;
    logic [1:0]  nextPCSel;
    logic [31:0] retired;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .run(run), .step_mode(step_mode),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_data(imem_data), .instruction(instruction), .instr_valid(instr_valid),
        .nextPCSel(nextPCSel), .halt(halt), .addr(addr), .reg_target(reg_target),
        .pc(pc), .halted(halted), .bad_npc(bad_npc), .retired(retired)
    );

    logic [15:0] mem [0:65535];
    int          lat = 1;
    bit          rand_lat = 1'b0;
    logic [15:0] rt = '0;
    int          vectors = 0;
    int          errors = 0;
    logic [15:0] m_pc;
    logic [31:0] m_ret;
    logic        m_bad;

    // toy decoder: op 111 halts, op 110 branches with select in [9:8], offset in [7:0]
    assign halt       = instruction[15:13] == 3'b111;
    assign nextPCSel  = instruction[15:13] == 3'b110 ? instruction[9:8] : 2'b00;
    assign addr       = {{8{instruction[7]}}, instruction[7:0]};
    assign reg_target = rt;

    // imem answers each request after lat cycles, independent of reset
    bit          pend = 1'b0;
    int          wcnt = 0;
    logic [15:0] raddr = '0;
    always @(posedge clk) begin
        imem_valid <= 1'b0;
        if (imem_req) begin
            raddr <= imem_addr;
            if (lat <= 1) begin
                imem_valid <= 1'b1;
                imem_data  <= mem[imem_addr];
                pend       <= 1'b0;
            end else begin
                pend <= 1'b1;
                wcnt <= lat - 1;
            end
        end else if (pend) begin
            if (wcnt <= 1) begin
                imem_valid <= 1'b1;
                imem_data  <= mem[raddr];
                pend       <= 1'b0;
            end else
                wcnt <= wcnt - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [15:0] ins,
                                             input logic [15:0] r, output logic b);
        int t;
        b = 1'b0;
        t = int'(p) + 1;
        if (ins[15:13] == 3'b110) begin
            if (ins[9:8] == 2'b01)      t = int'(p) + int'($signed(ins[7:0]));
            else if (ins[9:8] == 2'b10) t = int'(r);
            else if (ins[9:8] == 2'b11) b = 1'b1;
        end
        return 16'(t);
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:13] == 3'b111) w[15:13] = 3'b000;
        return w;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        run = 1'b0;
        step_mode = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        m_pc = 16'h0000;
        m_ret = 0;
        m_bad = 1'b0;
    endtask

    // run one instruction through the model; last drops run during its EXEC
    task automatic exec_step(input bit last, input logic [15:0] rtv);
        int          cyc;
        logic [15:0] nxt;
        logic        b;
        if (rand_lat) lat = $urandom_range(1, 3);
        rt = rtv;
        cyc = 0;
        while (!instr_valid && cyc < 40) begin
            if (imem_req) begin
                vectors++;
                if (imem_addr !== m_pc) begin
                    errors++;
                    $display("FAIL imem_addr: got %h want %h", imem_addr, m_pc);
                end
            end
            tick;
            cyc++;
        end
        vectors++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL exec_timeout: instr_valid got 0 want 1 within 40 cycles");
            return;
        end
        vectors++;
        if (instruction !== mem[m_pc]) begin
            errors++;
            $display("FAIL instruction: got %h want %h (pc %h)", instruction, mem[m_pc], m_pc);
        end
        if (last) run = 1'b0;
        if (mem[m_pc][15:13] == 3'b111) begin
            tick;
            vectors++;
            if ({halted, pc, retired} !== {1'b1, m_pc, m_ret}) begin
                errors++;
                $display("FAIL halt_state: got halted=%b pc=%h retired=%0d want 1 %h %0d",
                         halted, pc, retired, m_pc, m_ret);
            end
            return;
        end
        nxt = ref_next(m_pc, mem[m_pc], rtv, b);
        tick;
        m_pc = nxt;
        m_ret++;
        m_bad = m_bad | b;
        vectors++;
        if ({pc, retired, bad_npc, instr_valid} !== {m_pc, m_ret, m_bad, 1'b0}) begin
            errors++;
            $display("FAIL after_exec: got pc=%h ret=%0d bad=%b iv=%b want %h %0d %b 0",
                     pc, retired, bad_npc, instr_valid, m_pc, m_ret, m_bad);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        run = 1'b1;
        tick;
        tick;
        vectors++;
        if ({imem_req, instr_valid, halted, bad_npc} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {imem_req, instr_valid, halted, bad_npc});
        end
        vectors++;
        if (pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc: got %h want 0000", pc);
        end
        vectors++;
        if (instruction !== 16'h0000) begin
            errors++;
            $display("FAIL reset_instruction: got %h want 0000", instruction);
        end
        vectors++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired: got %0d want 0", retired);
        end
        vectors++;
        if (imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_imem_addr: got %h want 0000", imem_addr);
        end
        do_reset;
    endtask

    task automatic test_sequential;
        int c;
        do_reset;
        rand_lat = 1'b0;
        lat = 1;
        for (int i = 0; i < 3; i++) mem[i] = {3'b000, 13'($urandom)};
        mem[3] = 16'hE000;
        run = 1'b1;
        for (c = 0; c < 10; c++) begin
            vectors++;
            if (imem_req !== (c % 3 == 1)) begin
                errors++;
                $display("FAIL seq_req_cycle%0d: got %b want %b", c, imem_req, c % 3 == 1);
            end
            if (c % 3 == 1) begin
                vectors++;
                if ({pc, imem_addr} !== {16'(c / 3), 16'(c / 3)}) begin
                    errors++;
                    $display("FAIL seq_pc_cycle%0d: got pc=%h addr=%h want %h", c, pc, imem_addr, c / 3);
                end
            end
            tick;
        end
        c = 0;
        while (!halted && c < 20) begin
            tick;
            c++;
        end
        vectors++;
        if ({halted, pc, retired} !== {1'b1, 16'd3, 32'd3}) begin
            errors++;
            $display("FAIL seq_end: got halted=%b pc=%h retired=%0d want 1 0003 3", halted, pc, retired);
        end
    endtask

    task automatic test_branch;
        do_reset;
        rand_lat = 1'b1;
        mem[0] = 16'hC200;
        mem[10] = 16'hC1FB;
        mem[5] = 16'hC200;
        run = 1'b1;
        exec_step(1'b0, 16'd10);
        exec_step(1'b0, 16'($urandom));
        exec_step(1'b1, 16'd10);
        mem[10] = 16'hC100;
        tick;
        run = 1'b1;
        for (int i = 0; i < 3; i++) exec_step(i == 2, 16'($urandom));
        vectors++;
        if (pc !== 16'd10) begin
            errors++;
            $display("FAIL self_loop_pc: got %h want 000a", pc);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        rand_lat = 1'b1;
        mem[0] = 16'hC200;
        mem[16'hFFFF] = 16'h2345;
        run = 1'b1;
        exec_step(1'b0, 16'hFFFF);
        mem[0] = 16'hC300;
        mem[1] = 16'h6000;
        exec_step(1'b0, 16'($urandom));
        exec_step(1'b0, 16'($urandom));
        exec_step(1'b1, 16'($urandom));
        vectors++;
        if ({bad_npc, pc} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL bad_npc_sticky: got bad=%b pc=%h want 1 0002", bad_npc, pc);
        end
        do_reset;
        vectors++;
        if (bad_npc !== 1'b0) begin
            errors++;
            $display("FAIL bad_npc_reset: got %b want 0", bad_npc);
        end
    endtask

    task automatic test_halt;
        do_reset;
        rand_lat = 1'b1;
        mem[0] = 16'hC200;
        mem[7] = 16'hE000;
        run = 1'b1;
        exec_step(1'b0, 16'd7);
        exec_step(1'b0, 16'($urandom));
        for (int i = 0; i < 10; i++) begin
            run = 1'($urandom);
            tick;
            vectors++;
            if ({imem_req, halted, pc, retired} !== {1'b0, 1'b1, 16'd7, 32'd1}) begin
                errors++;
                $display("FAIL halted_hold: got req=%b halted=%b pc=%h ret=%0d want 0 1 0007 1",
                         imem_req, halted, pc, retired);
            end
        end
        do_reset;
        vectors++;
        if ({halted, pc, retired} !== {1'b0, 16'd0, 32'd0}) begin
            errors++;
            $display("FAIL halt_reset: got halted=%b pc=%h ret=%0d want 0 0000 0", halted, pc, retired);
        end
    endtask

    task automatic test_step;
        do_reset;
        rand_lat = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = rand_word() & 16'h1FFF;
        step_mode = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exec_step(1'b0, 16'($urandom));
            vectors++;
            if ({imem_req, instr_valid} !== 2'b00) begin
                errors++;
                $display("FAIL step_idle: got req=%b iv=%b want 0 0", imem_req, instr_valid);
            end
            tick;
            vectors++;
            if (imem_req !== 1'b1) begin
                errors++;
                $display("FAIL step_refetch: got req=%b want 1", imem_req);
            end
        end
        step_mode = 1'b0;
        rand_lat = 1'b0;
        lat = 3;
        tick;
        run = 1'b0;
        exec_step(1'b0, 16'($urandom));
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({imem_req, pc} !== {1'b0, 16'd4}) begin
                errors++;
                $display("FAIL run_drop_idle: got req=%b pc=%h want 0 0004", imem_req, pc);
            end
            tick;
        end
    endtask

    task automatic test_reset_wait;
        int c;
        do_reset;
        rand_lat = 1'b0;
        lat = 3;
        mem[0] = 16'h2468;
        run = 1'b1;
        c = 0;
        while (!imem_req && c < 10) begin
            tick;
            c++;
        end
        vectors++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rw_fetch: got req=%b want 1", imem_req);
        end
        tick;
        reset = 1'b1;
        run = 1'b0;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({instruction, instr_valid, pc, imem_req, retired} !== {16'd0, 1'b0, 16'd0, 1'b0, 32'd0}) begin
                errors++;
                $display("FAIL late_valid: got ins=%h iv=%b pc=%h req=%b ret=%0d want 0000 0 0000 0 0",
                         instruction, instr_valid, pc, imem_req, retired);
            end
            tick;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 65536; i++) mem[i] = rand_word();
        do_reset;
        rand_lat = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 40; i++) exec_step(i == 39, 16'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = rand_word();
        test_reset;
        test_sequential;
        test_branch;
        test_wrap;
        test_halt;
        test_step;
        test_reset_wait;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
